// File: rtl/cs_trgt_xchg.sv
// cs_trgt_xchg: target-side co-simulation exchange engine.
// Serves NUM_CH mission-clock domains from one utility clock. Each rising
// mission-clock edge is queued. The lowest pending channel is then served
// in one of three ways: it uploads a SUT snapshot, it waits frozen for a
// downloaded vector, or it does both. A watchdog releases a stuck channel
// instead of hanging. Error flags are sticky until reset.
module cs_trgt_xchg #(
    parameter  int NUM_CH   = 3,
    parameter  int DATA_W   = 8,
    parameter  int WDOG_MAX = 10000,
    parameter  int WDOG_W   = 16,
    localparam int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [NUM_CH-1:0]        mclk_i,
    input  logic                     put_en_i,
    input  logic                     get_en_i,
    output logic [NUM_CH-1:0]        freeze_clk_o,
    input  logic                     rx_valid_i,
    input  logic [CH_W-1:0]          rx_ch_i,
    input  logic [DATA_W:0]          rx_data_i,
    output logic                     rx_ready_o,
    output logic [NUM_CH-1:0]        dn_wen_o,
    output logic [NUM_CH*DATA_W-1:0] dn_data_o,
    input  logic                     up_valid_i,
    input  logic [DATA_W-1:0]        up_data_i,
    output logic                     tx_valid_o,
    input  logic                     tx_ready_i,
    output logic [CH_W-1:0]          tx_ch_o,
    output logic [DATA_W:0]          tx_data_o,
    output logic                     wdog_err_o,
    output logic                     mis_err_o,
    output logic                     ovr_err_o
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SEND    = 2'd1,
        ST_WAIT_RX = 2'd2
    } state_t;

    state_t                    r_state;
    state_t                    w_state_nxt;
    logic [NUM_CH-1:0]         r_mclk_q;
    logic [NUM_CH-1:0]         r_pending;
    logic [CH_W-1:0]           r_cur_ch;
    logic [WDOG_W-1:0]         r_wdog;
    logic [DATA_W:0]           r_tx_data;
    logic [CH_W-1:0]           r_tx_ch;
    logic [NUM_CH-1:0]         r_dn_wen;
    logic [NUM_CH*DATA_W-1:0]  r_dn_data;
    logic                      r_wdog_err;
    logic                      r_mis_err;
    logic                      r_ovr_err;

    logic [NUM_CH-1:0]         w_edge;
    logic [NUM_CH-1:0]         w_clr_mask;
    logic [NUM_CH-1:0]         w_busy_mask;
    logic [CH_W-1:0]           w_sel_ch;
    logic                      w_take;
    logic                      w_accept;
    logic                      w_match;
    logic                      w_mismatch;
    logic                      w_timeout;
    logic                      w_overrun;

    assign w_edge     = mclk_i & ~r_mclk_q;
    assign w_take     = (r_state == ST_IDLE) && (|r_pending);
    assign w_accept   = rx_valid_i && (r_state == ST_WAIT_RX);
    assign w_match    = w_accept && (rx_ch_i == r_cur_ch);
    assign w_mismatch = w_accept && (rx_ch_i != r_cur_ch);
    // A matching vector arriving on the last watchdog cycle still wins.
    assign w_timeout  = (r_state == ST_WAIT_RX) && !w_match
                        && (r_wdog == WDOG_W'(WDOG_MAX));
    assign w_overrun  = |(w_edge & (r_pending | w_busy_mask));

    // Lowest pending index wins; per-channel clear and in-service masks.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned and infers a latch.
        w_sel_ch    = '0;
        w_clr_mask  = '0;
        w_busy_mask = '0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            if (r_pending[k]) w_sel_ch = CH_W'(k);
        end
        for (int k = 0; k < NUM_CH; k++) begin
            w_clr_mask[k]  = w_take && (w_sel_ch == CH_W'(k));
            w_busy_mask[k] = (r_state != ST_IDLE) && (r_cur_ch == CH_W'(k));
        end
    end

    // Next-state decision and state-decoded handshake/freeze outputs.
    always_comb begin
        w_state_nxt  = r_state;
        freeze_clk_o = '0;
        rx_ready_o   = 1'b0;
        tx_valid_o   = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (w_take) begin
                    if (put_en_i)      w_state_nxt = ST_SEND;
                    else if (get_en_i) w_state_nxt = ST_WAIT_RX;
                end
            end
            ST_SEND: begin
                tx_valid_o = 1'b1;
                if (tx_ready_i) w_state_nxt = get_en_i ? ST_WAIT_RX : ST_IDLE;
            end
            ST_WAIT_RX: begin
                rx_ready_o = 1'b1;
                for (int k = 0; k < NUM_CH; k++) begin
                    freeze_clk_o[k] = (r_cur_ch == CH_W'(k));
                end
                if (w_match || w_timeout) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // State, edge history, pending queue and served-channel register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state   <= ST_IDLE;
            r_mclk_q  <= '0;
            r_pending <= '0;
            r_cur_ch  <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            r_state   <= w_state_nxt;
            r_mclk_q  <= mclk_i;
            // A fresh edge beats the clear, so an edge on the channel being taken re-queues it.
            r_pending <= (r_pending & ~w_clr_mask) | w_edge;
            if (w_take) r_cur_ch <= w_sel_ch;
        end
    end

    // Watchdog runs only while waiting, so it is zero on every WAIT_RX entry.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wdog <= '0;
        end else if (r_state == ST_WAIT_RX) begin
            r_wdog <= r_wdog + WDOG_W'(1);
        end else begin
            r_wdog <= '0;
        end
    end

    // Upload snapshot captured once on SEND entry and held until handshake.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            // NOTE: payload registers are reset here because every output must read 0 during reset.
            r_tx_data <= '0;
            r_tx_ch   <= '0;
        end else if (w_take && (w_state_nxt == ST_SEND)) begin
            r_tx_data <= {up_valid_i, up_data_i};
            r_tx_ch   <= w_sel_ch;
        end
    end

    // Downloaded vector lands only in the served channel's slice.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_dn_wen  <= '0;
            r_dn_data <= '0;
        end else if (w_match) begin
            for (int k = 0; k < NUM_CH; k++) begin
                if (r_cur_ch == CH_W'(k)) begin
                    r_dn_wen[k]                    <= rx_data_i[DATA_W];
                    r_dn_data[k*DATA_W +: DATA_W]  <= rx_data_i[DATA_W-1:0];
                end
            end
        end
    end

    // Sticky error flags, cleared only by reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wdog_err <= 1'b0;
            r_mis_err  <= 1'b0;
            r_ovr_err  <= 1'b0;
        end else begin
            if (w_timeout)  r_wdog_err <= 1'b1;
            if (w_mismatch) r_mis_err  <= 1'b1;
            if (w_overrun)  r_ovr_err  <= 1'b1;
        end
    end

    assign tx_data_o  = r_tx_data;
    assign tx_ch_o    = r_tx_ch;
    assign dn_wen_o   = r_dn_wen;
    assign dn_data_o  = r_dn_data;
    assign wdog_err_o = r_wdog_err;
    assign mis_err_o  = r_mis_err;
    assign ovr_err_o  = r_ovr_err;

endmodule

// File: tb/tb_cs_trgt_xchg.sv
// Directed testbench for cs_trgt_xchg (NUM_CH=3, DATA_W=8, WDOG_MAX=20).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_cs_trgt_xchg;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  mclk;
    logic        put_en;
    logic        get_en;
    logic [2:0]  freeze;
    logic        rx_valid;
    logic [1:0]  rx_ch;
    logic [8:0]  rx_data;
    logic        rx_ready;
    logic [2:0]  dn_wen;
    logic [23:0] dn_data;
    logic        up_valid;
    logic [7:0]  up_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [1:0]  tx_ch;
    logic [8:0]  tx_data;
    logic        wdog_err;
    logic        mis_err;
    logic        ovr_err;

    int n_checks = 0;
    int n_fail   = 0;

    cs_trgt_xchg #(
        .NUM_CH   (3),
        .DATA_W   (8),
        .WDOG_MAX (20),
        .WDOG_W   (16)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .mclk_i       (mclk),
        .put_en_i     (put_en),
        .get_en_i     (get_en),
        .freeze_clk_o (freeze),
        .rx_valid_i   (rx_valid),
        .rx_ch_i      (rx_ch),
        .rx_data_i    (rx_data),
        .rx_ready_o   (rx_ready),
        .dn_wen_o     (dn_wen),
        .dn_data_o    (dn_data),
        .up_valid_i   (up_valid),
        .up_data_i    (up_data),
        .tx_valid_o   (tx_valid),
        .tx_ready_i   (tx_ready),
        .tx_ch_o      (tx_ch),
        .tx_data_o    (tx_data),
        .wdog_err_o   (wdog_err),
        .mis_err_o    (mis_err),
        .ovr_err_o    (ovr_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic nedge(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_rx(input logic [1:0] ch, input logic [8:0] data);
        rx_valid = 1'b1;
        rx_ch    = ch;
        rx_data  = data;
        nedge(1);
        rx_valid = 1'b0;
    endtask

    initial begin
        rst      = 1'b1;
        mclk     = '0;
        put_en   = 1'b0;
        get_en   = 1'b0;
        rx_valid = 1'b0;
        rx_ch    = '0;
        rx_data  = '0;
        up_valid = 1'b0;
        up_data  = '0;
        tx_ready = 1'b0;

        // Reset state
        nedge(2);
        check("rst_freeze", {29'd0, freeze}, 32'd0);
        check("rst_txv", {31'd0, tx_valid}, 32'd0);
        check("rst_rxr", {31'd0, rx_ready}, 32'd0);
        check("rst_dn", {5'd0, dn_wen, dn_data}, 32'd0);
        check("rst_err", {29'd0, wdog_err, mis_err, ovr_err}, 32'd0);
        rst = 1'b0;
        nedge(1);

        // Single get: ch1 frozen 3 cycles, then {1,A5} lands in slice 1
        get_en = 1'b1;
        mclk   = 3'b010;
        nedge(1);
        check("get_pend_freeze", {29'd0, freeze}, 32'd0);
        mclk = 3'b000;
        for (int i = 0; i < 3; i++) begin
            nedge(1);
            check("get_freeze", {29'd0, freeze}, 32'h2);
            check("get_rxr", {31'd0, rx_ready}, 32'd1);
        end
        send_rx(2'd1, 9'h1A5);
        check("get_rel", {29'd0, freeze}, 32'd0);
        check("get_wen", {29'd0, dn_wen}, 32'h2);
        check("get_data", {8'd0, dn_data}, 32'h00A500);

        // Put+get: snapshot {1,3C} on ch0 held 5 cycles, ready late
        put_en   = 1'b1;
        up_valid = 1'b1;
        up_data  = 8'h3C;
        mclk     = 3'b001;
        nedge(1);
        check("pg_txv_early", {31'd0, tx_valid}, 32'd0);
        mclk = 3'b000;
        nedge(1);
        up_data = 8'h55;
        for (int i = 0; i < 5; i++) begin
            check("pg_txv", {31'd0, tx_valid}, 32'd1);
            check("pg_txd", {23'd0, tx_data}, 32'h13C);
            check("pg_txch", {30'd0, tx_ch}, 32'd0);
            check("pg_nofrz", {29'd0, freeze}, 32'd0);
            if (i == 4) tx_ready = 1'b1;
            nedge(1);
        end
        tx_ready = 1'b0;
        put_en   = 1'b0;
        check("pg_txv_done", {31'd0, tx_valid}, 32'd0);
        check("pg_freeze", {29'd0, freeze}, 32'h1);
        send_rx(2'd0, 9'h15A);
        check("pg_rel", {29'd0, freeze}, 32'd0);
        check("pg_wen", {29'd0, dn_wen}, 32'h3);
        check("pg_data", {8'd0, dn_data}, 32'h00A55A);

        // Priority: ch0 and ch2 together, ch0 first
        mclk = 3'b101;
        nedge(1);
        mclk = 3'b000;
        nedge(1);
        check("pri_first", {29'd0, freeze}, 32'h1);
        send_rx(2'd0, 9'h011);
        check("pri_gap", {29'd0, freeze}, 32'd0);
        check("pri_d0", {8'd0, dn_data}, 32'h00A511);
        nedge(1);
        check("pri_second", {29'd0, freeze}, 32'h4);
        send_rx(2'd2, 9'h1C3);
        check("pri_rel", {29'd0, freeze}, 32'd0);
        check("pri_wen", {29'd0, dn_wen}, 32'h6);
        check("pri_data", {8'd0, dn_data}, 32'hC3A511);
        check("pri_ovr", {31'd0, ovr_err}, 32'd0);
        check("pri_mis", {31'd0, mis_err}, 32'd0);

        // Overrun: second ch0 edge while ch0 waits
        mclk = 3'b001;
        nedge(1);
        mclk = 3'b000;
        nedge(1);
        check("ovr_frz", {29'd0, freeze}, 32'h1);
        check("ovr_pre", {31'd0, ovr_err}, 32'd0);
        mclk = 3'b001;
        nedge(1);
        mclk = 3'b000;
        check("ovr_set", {31'd0, ovr_err}, 32'd1);
        send_rx(2'd0, 9'h122);
        check("ovr_rel", {29'd0, freeze}, 32'd0);
        check("ovr_d1", {8'd0, dn_data}, 32'hC3A522);
        nedge(1);
        check("ovr_again", {29'd0, freeze}, 32'h1);
        send_rx(2'd0, 9'h033);
        check("ovr_d2", {8'd0, dn_data}, 32'hC3A533);
        check("ovr_wen", {29'd0, dn_wen}, 32'h6);
        nedge(1);
        check("ovr_once_a", {29'd0, freeze}, 32'd0);
        nedge(1);
        check("ovr_once_b", {29'd0, freeze}, 32'd0);

        // Mismatch + watchdog on ch1
        mclk = 3'b010;
        nedge(1);
        mclk = 3'b000;
        nedge(1);
        check("wd_frz1", {29'd0, freeze}, 32'h2);
        send_rx(2'd2, 9'h1FF);
        check("wd_mis", {31'd0, mis_err}, 32'd1);
        check("wd_frz2", {29'd0, freeze}, 32'h2);
        check("wd_dn_mis", {8'd0, dn_data}, 32'hC3A533);
        nedge(19);
        check("wd_frz21", {29'd0, freeze}, 32'h2);
        check("wd_err_pre", {31'd0, wdog_err}, 32'd0);
        nedge(1);
        check("wd_rel", {29'd0, freeze}, 32'd0);
        check("wd_err", {31'd0, wdog_err}, 32'd1);
        check("wd_rxr", {31'd0, rx_ready}, 32'd0);
        check("wd_dn", {5'd0, dn_wen, dn_data}, {5'd0, 3'h6, 24'hC3A533});

        // Reset mid-SEND, then normal service
        get_en   = 1'b0;
        put_en   = 1'b1;
        up_valid = 1'b0;
        up_data  = 8'h81;
        mclk     = 3'b100;
        nedge(1);
        mclk = 3'b000;
        nedge(1);
        check("rs_txv", {31'd0, tx_valid}, 32'd1);
        check("rs_txch", {30'd0, tx_ch}, 32'd2);
        check("rs_txd", {23'd0, tx_data}, 32'h081);
        #2;
        rst = 1'b1;
        #1;
        check("rs_txv_drop", {31'd0, tx_valid}, 32'd0);
        check("rs_tx_clr", {21'd0, tx_ch, tx_data}, 32'd0);
        check("rs_dn_clr", {5'd0, dn_wen, dn_data}, 32'd0);
        check("rs_err_clr", {29'd0, wdog_err, mis_err, ovr_err}, 32'd0);
        nedge(2);
        rst    = 1'b0;
        put_en = 1'b0;
        get_en = 1'b1;
        nedge(1);
        mclk = 3'b001;
        nedge(1);
        mclk = 3'b000;
        nedge(1);
        check("rs_frz", {29'd0, freeze}, 32'h1);
        send_rx(2'd0, 9'h144);
        check("rs_rel", {29'd0, freeze}, 32'd0);
        check("rs_dn", {5'd0, dn_wen, dn_data}, {5'd0, 3'h1, 24'h000044});

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cs_trgt_xchg.md
# cs_trgt_xchg

Parametrised target-side co-simulation exchange engine, the next generation of the per-interface target FSM. It serves `NUM_CH` mission-clock domains from one utility clock. On every rising mission-clock edge it optionally uploads a snapshot of SUT outputs to the initiator, then holds that mission clock frozen until the matching downloaded vector arrives. It sits between the transport adapter (fringe get/put side) and the SUT input/output pins. It adds a pending-edge queue, round-robin-free fixed priority, a handshaked upload path, a watchdog that recovers instead of finishing, and sticky error flags.

## Interface
- `NUM_CH`, 3: mission clock channels (1..8).
- `DATA_W`, 8: payload width per channel; vectors carry `{wen, data}` = `DATA_W+1` bits.
- `WDOG_MAX`, 10000: utility cycles allowed in WAIT_RX before timeout.
- `WDOG_W`, 16: watchdog counter width; must hold `WDOG_MAX`.
- `CH_W`: derived, `$clog2(NUM_CH)` (min 1).

Ports:
- `clk_i`  in  1  utility clock. One clock; all logic on its rising edge.
- `rst_i`  in  1  reset, asynchronous, active-high.
- `mclk_i`  in  NUM_CH  mission clock levels, already synchronous to `clk_i`.
- `put_en_i`  in  1  upload enable.
- `get_en_i`  in  1  download enable.
- `freeze_clk_o`  out  NUM_CH  per-channel mission clock hold.
- `rx_valid_i`  in  1  downloaded vector valid.
- `rx_ch_i`  in  CH_W  channel of the downloaded vector.
- `rx_data_i`  in  DATA_W+1  `{wen, data}`.
- `rx_ready_o`  out  1  vector accepted when `rx_valid_i && rx_ready_o`.
- `dn_wen_o`  out  NUM_CH  per-channel SUT write enable.
- `dn_data_o`  out  NUM_CH*DATA_W  per-channel SUT data; channel k is at `[k*DATA_W +: DATA_W]`.
- `up_valid_i`  in  1  SUT output valid.
- `up_data_i`  in  DATA_W  SUT output data.
- `tx_valid_o`  out  1  upload vector valid.
- `tx_ready_i`  in  1  transport accepts upload.
- `tx_ch_o`  out  CH_W  upload channel.
- `tx_data_o`  out  DATA_W+1  `{up_valid, up_data}` snapshot.
- `wdog_err_o`  out  1  sticky, watchdog expired.
- `mis_err_o`  out  1  sticky, rx vector for a channel other than the one being served.
- `ovr_err_o`  out  1  sticky, edge on a channel already pending.

## Operation
- **Edge detect:** `mclk_q <= mclk_i`. `edge[k] = mclk_i[k] & ~mclk_q[k]`. Each edge sets `pending[k]`.
- **Overrun:** if `edge[k]` and `pending[k]` are already set (or k is the channel in service), set `ovr_err_o`. The edge is merged and is not double-served.
- **FSM states:** IDLE, SEND, WAIT_RX. Register `cur_ch` holds the channel being served.
- **IDLE:** if `pending` is nonzero, select the lowest set index k, set `cur_ch=k`, and clear `pending[k]`. Next state:
  - `put_en_i` → SEND;
  - else `get_en_i` → WAIT_RX;
  - else stay in IDLE. The edge is consumed with no action.
- **SEND:** on entry, capture `tx_data_o={up_valid_i,up_data_i}` and `tx_ch_o=cur_ch`. `tx_valid_o=1` and the payload stays stable until `tx_ready_i`. On handshake: `get_en_i` → WAIT_RX, else → IDLE. The freeze for `cur_ch` is not asserted in SEND.
- **WAIT_RX:**
  - `rx_ready_o=1` and `freeze_clk_o[cur_ch]=1`.
  - Accepted vector with `rx_ch_i==cur_ch`: update `{dn_wen_o[cur_ch], dn_data_o slice}` and release the freeze. Go to IDLE.
  - Accepted vector with a mismatched channel: drop it, set `mis_err_o`, stay in WAIT_RX.
  - `wdog` counts cycles in WAIT_RX. When `wdog==WDOG_MAX`: set `wdog_err_o`, release the freeze, leave dn outputs unchanged, go to IDLE.
- **Counter reset:** `wdog` clears on every WAIT_RX entry.
- **Downloaded outputs:** non-served channels hold their `dn_*` values.
- **Error flags:** cleared only by `rst_i`.

## Timing
- **Reset values:** all outputs 0; `pending=0`; `mclk_q=0`; FSM=IDLE; `wdog=0`. A rising `mclk_i` present at reset release counts as an edge on the first clock.
- **Edge to service:** edge visible in cycle N, `pending` set at N+1, IDLE selects in N+1. SEND or WAIT_RX is active from N+2.
- **Freeze:** `freeze_clk_o` rises in the first WAIT_RX cycle.
- **Accept to release:** rx accept in cycle M gives `dn_*` updated and freeze low at M+1. The FSM is in IDLE at M+1.
- **Upload:** `tx_valid_o` rises in the first SEND cycle. A zero-wait handshake gives one cycle in SEND.
- **Watchdog:** timeout exits WAIT_RX after `WDOG_MAX+1` cycles in the state.
- **Simultaneous edge and in-flight service:** the new edge is queued. Same channel → overrun.
- **Mode change:** `put_en_i`/`get_en_i` are sampled only at IDLE decision and at SEND completion.
- **Asynchronous reset mid-operation:** aborts everything immediately. The freeze drops and `tx_valid_o` drops without handshake.

## Test plan
- **Single get:** NUM_CH=3, get only, edge on ch1, rx `{1,0xA5}` ch1 three cycles after entering WAIT_RX → `freeze_clk_o=3'b010` for 3 cycles, then `dn_wen_o[1]=1`, `dn_data_o[15:8]=0xA5`, freeze 0.
- **Put+get:** `up={1,0x3C}`, tx_ready delayed 4 cycles → tx_data `0x13C`, tx_ch 0 held stable 5 cycles; then WAIT_RX; rx completes as above.
- **Priority/queue:** edges on ch2 and ch0 in the same cycle → ch0 served first, ch2 next. `ovr_err_o` stays 0.
- **Overrun:** second ch0 edge while ch0 is in WAIT_RX → `ovr_err_o=1`; ch0 is served once more afterward.
- **Mismatch + watchdog:** WDOG_MAX=20, rx for ch2 while serving ch1 → `mis_err_o=1`. No matching rx arrives → `wdog_err_o=1` after 21 cycles, freeze released, `dn_*` unchanged.
- **Reset mid-SEND:** assert `rst_i` while `tx_valid_o=1` → all outputs 0 asynchronously; after release, a new edge is served normally.
